// File: rtl/image_host_pkg.sv
// Shared constants and types for the image host controller.
// Define FULL_RES_READOUT_EN to read back all 65536 pixels instead of the 16384-pixel downscaled result.
package image_host_pkg;
    localparam int PIX_W      = 8;
    localparam int ADDR_W     = 16;
    localparam int IMG_PIXELS = 65536;
    localparam int DS_PIXELS  = 16384;
`ifdef FULL_RES_READOUT_EN
    localparam int OUT_PIXELS = IMG_PIXELS;
`else
    localparam int OUT_PIXELS = DS_PIXELS;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PROCESS = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_OUT  = 3'd5
    } state_e;

    localparam logic [1:0] MC_HOLD = 2'b00;
    localparam logic [1:0] MC_LOAD = 2'b10;
    localparam logic [1:0] MC_PROC = 2'b01;
    localparam logic [1:0] MC_READ = 2'b11;
endpackage

// File: rtl/image_host_ctrl_if.sv
// Pixel-in stream, result-out stream and image-machine port of the host controller.
// master = controller side, slave = environment (source, sink and image machine).
interface image_host_ctrl_if;
    import image_host_pkg::*;

    logic              s_valid;
    logic [PIX_W-1:0]  s_data;
    logic              s_ready;

    logic              m_valid;
    logic [PIX_W-1:0]  m_data;
    logic              m_ready;
    logic              m_last;

    logic [1:0]        mc_status;
    logic [ADDR_W-1:0] mc_addr;
    logic [PIX_W-1:0]  mc_data;
    logic              mc_end_process;
    logic [PIX_W-1:0]  mc_out;

    modport master (
        input  s_valid, s_data, m_ready, mc_end_process, mc_out,
        output s_ready, m_valid, m_data, m_last, mc_status, mc_addr, mc_data
    );

    modport slave (
        output s_valid, s_data, m_ready, mc_end_process, mc_out,
        input  s_ready, m_valid, m_data, m_last, mc_status, mc_addr, mc_data
    );
endinterface

// File: rtl/image_host_ctrl.sv
// Host-side sequencer: loads a 256x256 frame into the image machine, waits for processing, streams results.
// FULL_RES_READOUT_EN selects full-resolution readout (65536 pixels) instead of downscaled (16384).
module image_host_ctrl
    import image_host_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    image_host_ctrl_if.master bus
);
    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] LOAD    = ST_LOAD;
    localparam logic [2:0] PROCESS = ST_PROCESS;
    localparam logic [2:0] RD_ADDR = ST_RD_ADDR;
    localparam logic [2:0] RD_WAIT = ST_RD_WAIT;
    localparam logic [2:0] RD_OUT  = ST_RD_OUT;

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(IMG_PIXELS - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST  = ADDR_W'(OUT_PIXELS - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        mc_status_q;
    logic [ADDR_W-1:0] mc_addr_q;
    logic [PIX_W-1:0]  mc_data_q;
    logic [PIX_W-1:0]  m_data_q;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mc_status_q <= MC_HOLD;
            mc_addr_q   <= '0;
            mc_data_q   <= '0;
            m_data_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    mc_status_q <= MC_HOLD;
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                // s_ready is high throughout LOAD, so s_valid alone is the handshake.
                LOAD: begin
                    if (bus.s_valid) begin
                        mc_status_q <= MC_LOAD;
                        mc_addr_q   <= cnt;
                        mc_data_q   <= bus.s_data;
                        cnt         <= cnt + 1'b1;
                        if (cnt == LOAD_LAST) state <= PROCESS;
                    end else begin
                        mc_status_q <= MC_HOLD;
                    end
                end
                PROCESS: begin
                    mc_status_q <= MC_PROC;
                    if (bus.mc_end_process) begin
                        state       <= RD_ADDR;
                        mc_status_q <= MC_READ;
                        mc_addr_q   <= cnt;
                    end
                end
                RD_ADDR: state <= RD_WAIT;
                // mc_addr has been stable for two edges by the time mc_out is captured here.
                RD_WAIT: begin
                    m_data_q <= bus.mc_out;
                    state    <= RD_OUT;
                end
                RD_OUT: begin
                    if (bus.m_ready) begin
                        if (cnt == OUT_LAST) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            done_q      <= 1'b1;
                            mc_status_q <= MC_HOLD;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            mc_addr_q <= cnt + 1'b1;
                            state     <= RD_ADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign bus.s_ready   = (state == LOAD);
    assign bus.m_valid   = (state == RD_OUT);
    assign bus.m_last    = (state == RD_OUT) && (cnt == OUT_LAST);
    assign bus.m_data    = m_data_q;
    assign bus.mc_status = mc_status_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_data   = mc_data_q;
endmodule

// File: tb/tb_image_host_ctrl.sv
// Randomized bench for image_host_ctrl against a phase-level model (load / process / readout).
// Honours FULL_RES_READOUT_EN through image_host_pkg::OUT_PIXELS.
module tb_image_host_ctrl;
    import image_host_pkg::*;

    localparam int M_IDLE = 0, M_LOAD = 1, M_PROC = 2, M_RD = 3;

    logic clk, rst_n, start, busy, done;
    image_host_ctrl_if bus();

    image_host_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    // Image machine returns a fixed function of the read address.
    assign bus.mc_out = bus.mc_addr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase-level model state
    int       mphase = M_IDLE;
    int       mcnt = 0, rd_idx = 0, pcnt = 0;
    bit       pend = 0, expect_done = 0;
    int       pend_addr = 0;
    logic [7:0] pend_data = '0;
    bit       hold_prev = 0;
    logic [7:0] hold_data = '0;
    logic [15:0] hold_addr = '0;
    int       stall_left = 0;
    bit       stalled = 0;
    int       writes = 0, beats = 0, lasts = 0, dones = 0;
    logic [7:0] pin0 = '0, pin1234 = '0, pinlast = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mphase = M_IDLE; mcnt = 0; rd_idx = 0; pcnt = 0;
            pend = 0; expect_done = 0; hold_prev = 0;
            bus.mc_end_process = 1'b0;
            bus.m_ready = 1'b0;
        end else begin
            chk("busy", busy, mphase != M_IDLE);
            chk("s_ready", bus.s_ready, mphase == M_LOAD);
            if (mphase != M_RD) chk("m_valid_outside_rd", bus.m_valid, 0);
            if (!bus.m_valid) chk("m_last_no_valid", bus.m_last, 0);
            chk("done", done, expect_done);
            expect_done = 0;
            if (done) dones++;

            if (pend) begin
                chk("wr_status", bus.mc_status, 2'b10);
                chk("wr_addr", bus.mc_addr, pend_addr);
                chk("wr_data", bus.mc_data, pend_data);
                writes++;
            end else begin
                case (mphase)
                    M_PROC:  chk("status_proc", bus.mc_status, 2'b01);
                    M_RD:    chk("status_rd", bus.mc_status, 2'b11);
                    default: chk("status_hold", bus.mc_status, 2'b00);
                endcase
            end

            if (mphase == M_RD) begin
                chk("rd_addr", bus.mc_addr, rd_idx);
                if (bus.m_valid) begin
                    chk("rd_data", bus.m_data, rd_idx[7:0] ^ 8'h5A);
                    chk("rd_last", bus.m_last, rd_idx == OUT_PIXELS - 1);
                    if (rd_idx == 0) pin0 = bus.m_data;
                    if (rd_idx == 'h1234) pin1234 = bus.m_data;
                    if (rd_idx == OUT_PIXELS - 1) pinlast = bus.m_data;
                end
            end

            if (hold_prev) begin
                chk("stall_valid", bus.m_valid, 1);
                chk("stall_data", bus.m_data, hold_data);
                chk("stall_addr", bus.mc_addr, hold_addr);
            end

            // Drive environment inputs for the coming edge.
            if (mphase == M_PROC) begin
                pcnt++;
                bus.mc_end_process = (pcnt == 500);
            end else begin
                bus.mc_end_process = 1'b0;
            end
            if (stall_left > 0) begin
                bus.m_ready = 1'b0;
                stall_left--;
            end else if (bus.m_valid && rd_idx == 5000 && !stalled) begin
                stalled = 1; stall_left = 19; bus.m_ready = 1'b0;
            end else begin
                bus.m_ready = ($urandom_range(0, 7) != 0);
            end
            hold_prev = bus.m_valid && !bus.m_ready;
            hold_data = bus.m_data;
            hold_addr = bus.mc_addr;

            // Advance the model across the coming edge.
            pend = 0;
            case (mphase)
                M_IDLE: if (start) begin mphase = M_LOAD; mcnt = 0; end
                M_LOAD: if (bus.s_valid) begin
                    pend = 1; pend_addr = mcnt; pend_data = bus.s_data;
                    if (mcnt == IMG_PIXELS - 1) begin
                        mphase = M_PROC; mcnt = 0; pcnt = 0;
                    end else mcnt++;
                end
                M_PROC: if (bus.mc_end_process) begin mphase = M_RD; rd_idx = 0; end
                M_RD: if (bus.m_valid && bus.m_ready) begin
                    beats++;
                    if (bus.m_last) lasts++;
                    if (rd_idx == OUT_PIXELS - 1) begin
                        mphase = M_IDLE; expect_done = 1;
                    end else rd_idx++;
                end
                default: mphase = M_IDLE;
            endcase
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_m_valid"}, bus.m_valid, 0);
        chk({tag, "_m_data"}, bus.m_data, 0);
        chk({tag, "_m_last"}, bus.m_last, 0);
        chk({tag, "_mc_status"}, bus.mc_status, 0);
        chk({tag, "_mc_addr"}, bus.mc_addr, 0);
        chk({tag, "_mc_data"}, bus.mc_data, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams pixels while the model is loading; gaps drop s_valid one cycle in three.
    task automatic load(input bit gaps, input int stop_at);
        int c = 0;
        while (mphase == M_LOAD && !(stop_at >= 0 && mcnt >= stop_at) && c < 200000) begin
            bus.s_valid = gaps ? (c % 3 != 2) : 1'b1;
            bus.s_data  = 8'($urandom);
            c++;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst0");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Frame A: gappy load, abandoned by reset at pixel 1000.
        do_start();
        load(1'b1, 1000);
        chk("busy_mid_load", busy, 1);
        chk("load_progress", mcnt, 1000);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Frame B: full load, process, readout with backpressure.
        writes = 0;
        do_start();
        load(1'b0, -1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (mphase != M_RD && n < 2000) begin @(posedge clk); #1; n++; end
        chk("reached_readout", mphase == M_RD, 1);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (mphase != M_IDLE && n < 400000) begin @(posedge clk); #1; n++; end
        chk("readout_finished", mphase == M_IDLE, 1);
        repeat (3) @(posedge clk);
        #1;

        chk("load_writes", writes, IMG_PIXELS);
        chk("beats", beats, OUT_PIXELS);
        chk("m_last_count", lasts, 1);
        chk("done_count", dones, 1);
        chk("stall_seen", stalled, 1);
        chk("pin_data0", pin0, 8'h5A);
        chk("pin_data1234", pin1234, 8'h6E);
        chk("pin_datalast", pinlast, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
